// File: rtl/registers_pkg.sv
// Shared widths and types for the SNULD 8-bit register file.
package registers_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int NUM_REGS   = 4;
  localparam int SEL_WIDTH  = 2;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [SEL_WIDTH-1:0]  reg_sel_t;

endpackage

// File: rtl/registers_reg_cell.sv
// Single data register with asynchronous active-low clear and load enable.
module reg_cell
  import registers_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  data_t data_d;
  data_t data_q;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/registers.sv
// 4 x 8-bit register file: one synchronous write port, two combinational read ports.
module registers
  import registers_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [SEL_WIDTH-1:0]  selector_a,
  input  logic [SEL_WIDTH-1:0]  selector_b,
  input  logic                  write_bit,
  input  logic [SEL_WIDTH-1:0]  selector_e,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out_a,
  output logic [DATA_WIDTH-1:0] data_out_b
);

  logic [NUM_REGS-1:0] load_en;
  data_t               reg_val [NUM_REGS];

  // One-hot write decode; at most one cell loads per edge.
  always_comb begin
    load_en = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      load_en[i] = write_bit && (selector_e == reg_sel_t'(i));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    reg_cell u_cell (
      .clk   (CLK),
      .rst_n (RESET_N),
      .load  (load_en[g]),
      .d     (data_in),
      .q     (reg_val[g])
    );
  end

  // Reads come straight off the cells, so a write shows up only after its edge.
  always_comb begin
    data_out_a = reg_val[selector_a];
    data_out_b = reg_val[selector_b];
  end

endmodule

// File: tb/tb_registers.sv
// Directed self-checking bench for the registers file.
module tb_registers;

  logic       CLK;
  logic       RESET_N;
  logic [1:0] selector_a;
  logic [1:0] selector_b;
  logic       write_bit;
  logic [1:0] selector_e;
  logic [7:0] data_in;
  logic [7:0] data_out_a;
  logic [7:0] data_out_b;

  int checks;
  int failures;

  registers dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .selector_a (selector_a),
    .selector_b (selector_b),
    .write_bit  (write_bit),
    .selector_e (selector_e),
    .data_in    (data_in),
    .data_out_a (data_out_a),
    .data_out_b (data_out_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_write(input logic [1:0] sel, input logic [7:0] val);
    @(negedge CLK);
    write_bit  = 1'b1;
    selector_e = sel;
    data_in    = val;
    @(posedge CLK);
    #1;
    write_bit = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    for (int i = 0; i < 4; i++) begin
      selector_a = 2'(i);
      selector_b = 2'(3 - i);
      #1;
      checks++;
      if (data_out_a !== 8'h00) begin
        failures++;
        $display("[TB] FAIL reset_a[%0d]: got %h expected 00", i, data_out_a);
      end
      checks++;
      if (data_out_b !== 8'h00) begin
        failures++;
        $display("[TB] FAIL reset_b[%0d]: got %h expected 00", 3 - i, data_out_b);
      end
    end
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic test_basic_write();
    do_write(2'd0, 8'h07);
    selector_a = 2'd0;
    selector_b = 2'd1;
    #1;
    checks++;
    if (data_out_a !== 8'h07) begin
      failures++;
      $display("[TB] FAIL basic_write_a: got %h expected 07", data_out_a);
    end
    checks++;
    if (data_out_b !== 8'h00) begin
      failures++;
      $display("[TB] FAIL basic_write_b: got %h expected 00", data_out_b);
    end
  endtask

  task automatic test_write_all();
    logic [7:0] exp_vals [4];
    exp_vals[0] = 8'h11;
    exp_vals[1] = 8'h22;
    exp_vals[2] = 8'h33;
    exp_vals[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      do_write(2'(i), exp_vals[i]);
    end
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        selector_a = 2'(a);
        selector_b = 2'(b);
        #1;
        checks++;
        if (data_out_a !== exp_vals[a]) begin
          failures++;
          $display("[TB] FAIL write_all_a[%0d]: got %h expected %h", a, data_out_a, exp_vals[a]);
        end
        checks++;
        if (data_out_b !== exp_vals[b]) begin
          failures++;
          $display("[TB] FAIL write_all_b[%0d]: got %h expected %h", b, data_out_b, exp_vals[b]);
        end
      end
    end
  endtask

  task automatic test_write_disable();
    @(negedge CLK);
    write_bit  = 1'b0;
    selector_e = 2'd2;
    data_in    = 8'hAA;
    @(posedge CLK);
    #1;
    selector_a = 2'd2;
    selector_b = 2'd2;
    #1;
    checks++;
    if (data_out_a !== 8'h33) begin
      failures++;
      $display("[TB] FAIL write_disable_a: got %h expected 33", data_out_a);
    end
    checks++;
    if (data_out_b !== 8'h33) begin
      failures++;
      $display("[TB] FAIL write_disable_b: got %h expected 33", data_out_b);
    end
  endtask

  task automatic test_no_bypass();
    selector_a = 2'd1;
    @(negedge CLK);
    write_bit  = 1'b1;
    selector_e = 2'd1;
    data_in    = 8'h5C;
    #1;
    checks++;
    if (data_out_a !== 8'h22) begin
      failures++;
      $display("[TB] FAIL no_bypass_before: got %h expected 22", data_out_a);
    end
    @(posedge CLK);
    #1;
    write_bit = 1'b0;
    checks++;
    if (data_out_a !== 8'h5C) begin
      failures++;
      $display("[TB] FAIL no_bypass_after: got %h expected 5c", data_out_a);
    end
  endtask

  task automatic test_async_reset();
    selector_a = 2'd3;
    selector_b = 2'd1;
    @(negedge CLK);
    #1;
    checks++;
    if (data_out_a !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL pre_reset_a: got %h expected ff", data_out_a);
    end
    RESET_N = 1'b0;
    #1;
    checks++;
    if (data_out_a !== 8'h00) begin
      failures++;
      $display("[TB] FAIL async_reset_a: got %h expected 00", data_out_a);
    end
    checks++;
    if (data_out_b !== 8'h00) begin
      failures++;
      $display("[TB] FAIL async_reset_b: got %h expected 00", data_out_b);
    end
    // Write attempted while reset is still held must be dropped.
    do_write(2'd0, 8'h77);
    selector_a = 2'd0;
    #1;
    checks++;
    if (data_out_a !== 8'h00) begin
      failures++;
      $display("[TB] FAIL write_in_reset: got %h expected 00", data_out_a);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    do_write(2'd3, 8'h01);
    for (int i = 0; i < 4; i++) begin
      selector_a = 2'(i);
      selector_b = 2'(i);
      #1;
      checks++;
      if (data_out_a !== ((i == 3) ? 8'h01 : 8'h00)) begin
        failures++;
        $display("[TB] FAIL post_reset_a[%0d]: got %h expected %h", i, data_out_a,
                 (i == 3) ? 8'h01 : 8'h00);
      end
      checks++;
      if (data_out_b !== ((i == 3) ? 8'h01 : 8'h00)) begin
        failures++;
        $display("[TB] FAIL post_reset_b[%0d]: got %h expected %h", i, data_out_b,
                 (i == 3) ? 8'h01 : 8'h00);
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    RESET_N    = 1'b1;
    selector_a = 2'd0;
    selector_b = 2'd0;
    write_bit  = 1'b0;
    selector_e = 2'd0;
    data_in    = 8'h00;
    #2;
    test_reset();
    test_basic_write();
    test_write_all();
    test_write_disable();
    test_no_bypass();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
